// File: rtl/bids22defs.sv
// Shared types and constants for the bids22 auction controller and its bidder agents.
package bids22defs;

    typedef enum logic [1:0] {
        NOBIDERROR        = 2'd0,
        INVALIDREQUEST    = 2'd1,
        INSUFFICIENTFUNDS = 2'd2,
        BIDERR_RSVD       = 2'd3
    } bid_err_t;

    typedef enum logic [2:0] {
        AG_IDLE    = 3'd0,
        AG_ARMED   = 3'd1,
        AG_EVAL    = 3'd2,
        AG_BID     = 3'd3,
        AG_HOLD    = 3'd4,
        AG_BACKOFF = 3'd5,
        AG_GIVEUP  = 3'd6,
        AG_RESULT  = 3'd7
    } agent_state_t;

    // Plain-vector aliases of the agent states, as carried on the agent_state debug port.
    localparam logic [2:0] S_IDLE    = AG_IDLE;
    localparam logic [2:0] S_ARMED   = AG_ARMED;
    localparam logic [2:0] S_EVAL    = AG_EVAL;
    localparam logic [2:0] S_BID     = AG_BID;
    localparam logic [2:0] S_HOLD    = AG_HOLD;
    localparam logic [2:0] S_BACKOFF = AG_BACKOFF;
    localparam logic [2:0] S_GIVEUP  = AG_GIVEUP;
    localparam logic [2:0] S_RESULT  = AG_RESULT;

    localparam int BIDS_MAXBIDS = 255;

endpackage

// File: rtl/bid_backoff_ctr.sv
// Backoff counter: load sets BACKOFF-1, so the BACKOFF state lasts exactly BACKOFF cycles.
module bid_backoff_ctr #(
    parameter int BACKOFF = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int CW = (BACKOFF < 2) ? 1 : $clog2(BACKOFF);
    localparam logic [CW-1:0] LOADV = CW'((BACKOFF > 0) ? BACKOFF - 1 : 0);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= LOADV;
        end else if (dec && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/bid_agent.sv
// Bidder-side agent for one port of the bids22 auction controller: outbids the
// current maximum each round until it wins, reaches its cap or runs out of funds.
module bid_agent
    import bids22defs::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int BACKOFF   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_load,
    input  logic [DATAWIDTH-1:0] cfg_start,
    input  logic [DATAWIDTH-1:0] cfg_cap,
    input  logic [DATAWIDTH-1:0] cfg_step,
    input  logic [DATAWIDTH-1:0] cfg_charge,
    input  logic                 withdraw,
    input  logic                 round_active,
    input  logic                 round_over,
    input  logic [DATAWIDTH-1:0] max_bid,
    input  logic                 ack,
    input  logic [1:0]           bid_err,
    input  logic                 win,
    input  logic [DATAWIDTH-1:0] balance,
    output logic                 bid,
    output logic [DATAWIDTH-1:0] bid_amt,
    output logic                 retract,
    output logic [DATAWIDTH-1:0] last_bid,
    output logic                 won,
    output logic                 done,
    output logic                 gave_up,
    output logic [7:0]           bids_placed,
    output logic [2:0]           agent_state
);

    logic [DATAWIDTH-1:0] start_q, cap_q, step_q, charge_q, cand_q;
    logic [DATAWIDTH:0]   cand_w, cost_w;
    logic [2:0]           nxt;
    logic over_cap, short_funds, leading, outbid, in_round, accepted;
    logic bo_load, bo_dec, bo_zero;

    // Candidate and affordability use one extra bit so a wrapped sum is caught as a carry.
    assign cand_w      = (max_bid == '0) ? {1'b0, start_q} : {1'b0, max_bid} + {1'b0, step_q};
    assign over_cap    = cand_w[DATAWIDTH] || (cand_w[DATAWIDTH-1:0] > cap_q);
    assign cost_w      = cand_w + {1'b0, charge_q};
    assign short_funds = cost_w > {1'b0, balance};
    assign leading     = (max_bid == last_bid) && (last_bid != '0);
    assign outbid      = max_bid > last_bid;
    assign in_round    = agent_state inside {S_EVAL, S_BID, S_HOLD, S_BACKOFF, S_GIVEUP};

    // Handshake: bid is a one-cycle request that never stalls; the controller answers with
    // ack/bid_err combinationally in that same cycle. An explicit error outranks ack.
    assign accepted = ack && !((bid_err == INSUFFICIENTFUNDS) || (bid_err == INVALIDREQUEST));
    assign bid      = (agent_state == S_BID) && round_active;
    assign bid_amt  = bid ? cand_q : '0;
    assign retract  = (agent_state == S_HOLD) && round_active && withdraw;

    bid_backoff_ctr #(.BACKOFF(BACKOFF)) u_backoff (
        .clk   (clk),
        .reset (reset),
        .load  (bo_load),
        .dec   (bo_dec),
        .zero  (bo_zero)
    );

    always_comb begin
        nxt     = agent_state;
        bo_load = 1'b0;
        bo_dec  = 1'b0;
        case (agent_state)
            S_IDLE:    if (cfg_load) nxt = S_ARMED;
            S_ARMED:   if (round_active) nxt = S_EVAL;
            S_EVAL: begin
                if (over_cap || short_funds) nxt = S_GIVEUP;
                else if (leading)            nxt = S_HOLD;
                else                         nxt = S_BID;
            end
            S_BID:     nxt = accepted ? S_HOLD : S_GIVEUP;
            S_HOLD: begin
                if (withdraw) begin
                    nxt = S_GIVEUP;
                end else if (outbid) begin
                    if (BACKOFF == 0) begin
                        nxt = S_EVAL;
                    end else begin
                        nxt     = S_BACKOFF;
                        bo_load = 1'b1;
                    end
                end
            end
            S_BACKOFF: begin
                if (bo_zero) nxt = S_EVAL;
                else         bo_dec = 1'b1;
            end
            S_GIVEUP:  nxt = S_GIVEUP;
            S_RESULT:  if (round_over || round_active) nxt = S_ARMED;
            default:   nxt = S_IDLE;
        endcase
        // The round closing overrides whatever the in-round state wanted to do.
        if (in_round && !round_active) begin
            nxt     = S_RESULT;
            bo_load = 1'b0;
            bo_dec  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            agent_state <= S_IDLE;
            start_q     <= '0;
            cap_q       <= '0;
            step_q      <= '0;
            charge_q    <= '0;
            cand_q      <= '0;
            last_bid    <= '0;
            won         <= 1'b0;
            done        <= 1'b0;
            gave_up     <= 1'b0;
            bids_placed <= '0;
        end else begin
            agent_state <= nxt;
            done        <= 1'b0;
            if (cfg_load && ((agent_state == S_IDLE) || (agent_state == S_ARMED))) begin
                start_q  <= cfg_start;
                cap_q    <= cfg_cap;
                step_q   <= cfg_step;
                charge_q <= cfg_charge;
            end
            if ((agent_state == S_ARMED) && round_active) begin
                won         <= 1'b0;
                gave_up     <= 1'b0;
                bids_placed <= '0;
                last_bid    <= '0;
            end
            if (agent_state == S_EVAL) cand_q <= cand_w[DATAWIDTH-1:0];
            if (bid && accepted) begin
                last_bid <= cand_q;
                if (bids_placed != 8'(BIDS_MAXBIDS)) bids_placed <= bids_placed + 8'd1;
            end
            if (retract) last_bid <= '0;
            if ((nxt == S_GIVEUP) && (agent_state != S_GIVEUP)) gave_up <= 1'b1;
            if (agent_state == S_RESULT) begin
                if (round_over) begin
                    won  <= win;
                    done <= 1'b1;
                end else if (round_active) begin
                    won  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bid_agent.sv
// Directed bench for bid_agent: a 32-bit agent through win, outbid, funds, withdraw and
// reset rounds, plus an 8-bit zero-backoff agent for carry detection.
module tb_bid_agent;

    localparam int W  = 32;
    localparam int WB = 8;
    localparam logic [2:0] T_IDLE = 3'd0, T_ARMED = 3'd1, T_EVAL = 3'd2, T_BID = 3'd3;
    localparam logic [2:0] T_HOLD = 3'd4, T_BACKOFF = 3'd5, T_GIVEUP = 3'd6, T_RESULT = 3'd7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int bids_seen_a = 0, retracts_a = 0, dones_a = 0, bids_seen_b = 0;
    int ack_mode = 0;
    logic [W-1:0]  exp_q[$];
    logic [WB-1:0] exp_q_b[$];

    logic          rst_a, cfg_load_a, withdraw_a, round_active_a, round_over_a, win_a, ack_a;
    logic [1:0]    bid_err_a;
    logic [W-1:0]  cfg_start_a, cfg_cap_a, cfg_step_a, cfg_charge_a, max_bid_a, balance_a;
    logic          bid_a, retract_a, won_a, done_a, gave_up_a;
    logic [W-1:0]  bid_amt_a, last_bid_a;
    logic [7:0]    bids_placed_a;
    logic [2:0]    state_a;

    logic          rst_b, cfg_load_b, round_active_b, round_over_b, ack_b;
    logic [WB-1:0] cfg_start_b, cfg_cap_b, cfg_step_b, cfg_charge_b, max_bid_b, balance_b;
    logic          bid_b, retract_b, won_b, done_b, gave_up_b;
    logic [WB-1:0] bid_amt_b, last_bid_b;
    logic [7:0]    bids_placed_b;
    logic [2:0]    state_b;

    // Controller stand-ins answering in the same cycle as the request.
    assign ack_a     = bid_a && (ack_mode == 0);
    assign bid_err_a = (bid_a && (ack_mode == 1)) ? 2'd2 : 2'd0;
    assign ack_b     = bid_b;

    bid_agent #(.DATAWIDTH(W), .BACKOFF(2)) dut_a (
        .clk(clk), .reset(rst_a), .cfg_load(cfg_load_a), .cfg_start(cfg_start_a),
        .cfg_cap(cfg_cap_a), .cfg_step(cfg_step_a), .cfg_charge(cfg_charge_a),
        .withdraw(withdraw_a), .round_active(round_active_a), .round_over(round_over_a),
        .max_bid(max_bid_a), .ack(ack_a), .bid_err(bid_err_a), .win(win_a),
        .balance(balance_a), .bid(bid_a), .bid_amt(bid_amt_a), .retract(retract_a),
        .last_bid(last_bid_a), .won(won_a), .done(done_a), .gave_up(gave_up_a),
        .bids_placed(bids_placed_a), .agent_state(state_a)
    );

    bid_agent #(.DATAWIDTH(WB), .BACKOFF(0)) dut_b (
        .clk(clk), .reset(rst_b), .cfg_load(cfg_load_b), .cfg_start(cfg_start_b),
        .cfg_cap(cfg_cap_b), .cfg_step(cfg_step_b), .cfg_charge(cfg_charge_b),
        .withdraw(1'b0), .round_active(round_active_b), .round_over(round_over_b),
        .max_bid(max_bid_b), .ack(ack_b), .bid_err(2'd0), .win(1'b0),
        .balance(balance_b), .bid(bid_b), .bid_amt(bid_amt_b), .retract(retract_b),
        .last_bid(last_bid_b), .won(won_b), .done(done_b), .gave_up(gave_up_b),
        .bids_placed(bids_placed_b), .agent_state(state_b)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard side: every bid seen is matched against the oldest expected amount.
    always @(negedge clk) begin
        if (bid_a) begin
            bids_seen_a++;
            if (exp_q.size() == 0) chk("a_unexpected_bid", W'(bid_a), '0);
            else                   chk("a_bid_amt", bid_amt_a, exp_q.pop_front());
        end
        if (retract_a) retracts_a++;
        if (done_a)    dones_a++;
        if (bid_b) begin
            bids_seen_b++;
            if (exp_q_b.size() == 0) chk("b_unexpected_bid", W'(bid_b), '0);
            else                     chk("b_bid_amt", W'(bid_amt_b), W'(exp_q_b.pop_front()));
        end
    end

    initial begin
        rst_a = 1'b1; cfg_load_a = 1'b0; withdraw_a = 1'b0; round_active_a = 1'b0;
        round_over_a = 1'b0; win_a = 1'b0; cfg_start_a = '0; cfg_cap_a = '0;
        cfg_step_a = '0; cfg_charge_a = '0; max_bid_a = '0; balance_a = '0;
        rst_b = 1'b1; cfg_load_b = 1'b0; round_active_b = 1'b0; round_over_b = 1'b0;
        cfg_start_b = '0; cfg_cap_b = '0; cfg_step_b = '0; cfg_charge_b = '0;
        max_bid_b = '0; balance_b = '0;
        cyc(2);
        chk("rst_state", W'(state_a), W'(T_IDLE));
        chk("rst_bid", W'(bid_a), 0);
        chk("rst_last_bid", last_bid_a, 0);
        chk("rst_flags", W'({won_a, done_a, gave_up_a, retract_a}), 0);
        chk("rst_bids_placed", W'(bids_placed_a), 0);
        rst_a = 1'b0; rst_b = 1'b0;

        // Solo win
        cfg_load_a = 1'b1; cfg_start_a = 10; cfg_cap_a = 50; cfg_step_a = 5; cfg_charge_a = 1;
        balance_a = 100; max_bid_a = 0;
        cyc(1);
        chk("armed", W'(state_a), W'(T_ARMED));
        cfg_load_a = 1'b0; round_active_a = 1'b1; exp_q.push_back(10);
        cyc(1); chk("solo_eval", W'(state_a), W'(T_EVAL));
        cyc(1); chk("solo_bid", W'(state_a), W'(T_BID));
        cyc(1);
        chk("solo_hold", W'(state_a), W'(T_HOLD));
        chk("solo_last_bid", last_bid_a, 10);
        chk("solo_bids_placed", W'(bids_placed_a), 1);
        max_bid_a = 10;
        cyc(2); chk("solo_still_hold", W'(state_a), W'(T_HOLD));
        round_active_a = 1'b0;
        cyc(1); chk("solo_result", W'(state_a), W'(T_RESULT));
        win_a = 1'b1; round_over_a = 1'b1;
        cyc(1);
        chk("solo_done", W'(done_a), 1);
        chk("solo_won", W'(won_a), 1);
        chk("solo_rearmed", W'(state_a), W'(T_ARMED));
        round_over_a = 1'b0; win_a = 1'b0;
        cyc(1);
        chk("solo_done_pulse", W'(done_a), 0);
        chk("solo_won_sticky", W'(won_a), 1);
        chk("solo_done_count", W'(dones_a), 1);

        // Outbid ladder
        max_bid_a = 0; round_active_a = 1'b1; exp_q.push_back(10);
        cyc(1);
        chk("lad_won_cleared", W'(won_a), 0);
        chk("lad_count_cleared", W'(bids_placed_a), 0);
        cyc(2); chk("lad_last_bid", last_bid_a, 10);
        max_bid_a = 20; exp_q.push_back(25);
        cyc(1); chk("lad_backoff1", W'(state_a), W'(T_BACKOFF));
        cyc(1); chk("lad_backoff2", W'(state_a), W'(T_BACKOFF));
        cyc(1); chk("lad_eval", W'(state_a), W'(T_EVAL));
        chk("lad_no_early_bid", W'(bids_seen_a), 2);
        cyc(1); chk("lad_bid", W'(state_a), W'(T_BID));
        cyc(1);
        chk("lad_last_bid2", last_bid_a, 25);
        chk("lad_bids_placed", W'(bids_placed_a), 2);
        chk("lad_bids_seen", W'(bids_seen_a), 3);
        max_bid_a = 48;
        cyc(4);
        chk("lad_cap_giveup", W'(state_a), W'(T_GIVEUP));
        chk("lad_gave_up", W'(gave_up_a), 1);
        chk("lad_last_kept", last_bid_a, 25);
        round_active_a = 1'b0;
        cyc(1); round_over_a = 1'b1;
        cyc(1);
        chk("lad_done", W'(done_a), 1);
        chk("lad_not_won", W'(won_a), 0);
        round_over_a = 1'b0;

        // Funds: pre-check failure, then controller-side INSUFFICIENTFUNDS
        cfg_load_a = 1'b1; cfg_charge_a = 3; balance_a = 12; max_bid_a = 0;
        cyc(1);
        cfg_load_a = 1'b0; round_active_a = 1'b1;
        cyc(1); chk("fund_gave_up_clr", W'(gave_up_a), 0);
        cyc(1);
        chk("fund_giveup", W'(state_a), W'(T_GIVEUP));
        chk("fund_no_bid", W'(bids_seen_a), 3);
        round_active_a = 1'b0;
        cyc(1);
        round_active_a = 1'b1; balance_a = 100; ack_mode = 1; exp_q.push_back(10);
        cyc(1);
        chk("early_restart_done", W'(done_a), 1);
        chk("early_restart_won", W'(won_a), 0);
        cyc(3);
        chk("insuf_giveup", W'(state_a), W'(T_GIVEUP));
        chk("insuf_last_bid", last_bid_a, 0);
        chk("insuf_bids_placed", W'(bids_placed_a), 0);
        round_active_a = 1'b0; ack_mode = 0;
        cyc(1); round_over_a = 1'b1;
        cyc(1); round_over_a = 1'b0;

        // Withdraw and outbid in the same cycle
        cfg_load_a = 1'b1; cfg_start_a = 30; cfg_cap_a = 100; cfg_step_a = 5; cfg_charge_a = 1;
        balance_a = 200; max_bid_a = 0;
        cyc(1);
        cfg_load_a = 1'b0; round_active_a = 1'b1; exp_q.push_back(30);
        cyc(3); chk("wd_last_bid", last_bid_a, 30);
        max_bid_a = 30;
        cyc(1);
        withdraw_a = 1'b1; max_bid_a = 40;
        cyc(1);
        withdraw_a = 1'b0;
        chk("wd_giveup", W'(state_a), W'(T_GIVEUP));
        chk("wd_last_cleared", last_bid_a, 0);
        chk("wd_retract", W'(retracts_a), 1);
        cyc(2);
        chk("wd_retract_once", W'(retracts_a), 1);
        chk("wd_no_rebid", W'(bids_seen_a), 5);
        round_active_a = 1'b0;
        cyc(1); round_over_a = 1'b1;
        cyc(1); round_over_a = 1'b0;

        // Round ends during backoff; cfg_load while holding must be ignored
        max_bid_a = 0; round_active_a = 1'b1; exp_q.push_back(30);
        cyc(3);
        max_bid_a = 40; cfg_load_a = 1'b1; cfg_start_a = 77;
        cyc(1);
        cfg_load_a = 1'b0;
        chk("end_backoff", W'(state_a), W'(T_BACKOFF));
        round_active_a = 1'b0;
        cyc(1); chk("end_result", W'(state_a), W'(T_RESULT));
        cyc(3);
        chk("end_result_held", W'(state_a), W'(T_RESULT));
        chk("end_no_bid", W'(bids_seen_a), 6);
        round_over_a = 1'b1; max_bid_a = 0;
        cyc(1);
        round_over_a = 1'b0; round_active_a = 1'b1; exp_q.push_back(30);
        cyc(2); chk("rst_mid_bid_state", W'(state_a), W'(T_BID));
        rst_a = 1'b1;
        cyc(1);
        chk("rstm_state", W'(state_a), W'(T_IDLE));
        chk("rstm_bid", W'({bid_a, retract_a}), 0);
        chk("rstm_last_bid", last_bid_a, 0);
        chk("rstm_flags", W'({won_a, done_a, gave_up_a}), 0);
        chk("rstm_bids_placed", W'(bids_placed_a), 0);
        rst_a = 1'b0;

        // 8-bit agent: carry out of max_bid+step, then zero-backoff rebid
        cfg_load_b = 1'b1; cfg_start_b = 1; cfg_cap_b = 255; cfg_step_b = 10;
        cfg_charge_b = 0; balance_b = 255; max_bid_b = 250;
        cyc(1);
        cfg_load_b = 1'b0; round_active_b = 1'b1;
        cyc(2);
        chk("ovf_giveup", W'(state_b), W'(T_GIVEUP));
        chk("ovf_gave_up", W'(gave_up_b), 1);
        chk("ovf_no_bid", W'(bids_seen_b), 0);
        round_active_b = 1'b0;
        cyc(1); round_over_b = 1'b1; max_bid_b = 100;
        cyc(1);
        round_over_b = 1'b0; round_active_b = 1'b1; exp_q_b.push_back(110);
        cyc(3); chk("b_last_bid", W'(last_bid_b), 110);
        max_bid_b = 120; exp_q_b.push_back(130);
        cyc(1); chk("b_zero_backoff", W'(state_b), W'(T_EVAL));
        cyc(2);
        chk("b_last_bid2", W'(last_bid_b), 130);
        chk("b_bids_placed", W'(bids_placed_b), 2);

        chk("a_queue_drained", W'(exp_q.size()), 0);
        chk("b_queue_drained", W'(exp_q_b.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bid_agent.md
Name: bid_agent

Overview:
- Autonomous bidder-side agent. It drives one bidder port of the bids22 auction controller: it issues bid and retract requests and consumes ack, err, win and the controller's maxBid.
- A host loads a start bid, a cap, an increment and the bid charge. During a round the agent outbids the current maximum until it wins or hits its cap or funds.
- One instance per bidder (X/Y/Z) in system-level benches and SoC integration.

Parameters:
- DATAWIDTH, 32, width of amounts, balance and maxBid.
- BACKOFF, 2, idle cycles after being outbid before re-evaluating (0 allowed).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cfg_load  in  1  one-cycle strobe; captures cfg_* (honoured only in IDLE or ARMED).
- cfg_start  in  DATAWIDTH  first bid amount when maxBid is 0.
- cfg_cap  in  DATAWIDTH  highest amount the agent will ever bid.
- cfg_step  in  DATAWIDTH  increment over maxBid.
- cfg_charge  in  DATAWIDTH  per-bid charge (mirror of controller's SETBIDCHARGE).
- withdraw  in  1  host request to retract a standing bid.
- round_active  in  1  controller C_start as seen by bidders.
- round_over  in  1  controller roundOver pulse.
- max_bid  in  DATAWIDTH  controller maxBid.
- ack  in  1  bid accepted.
- bid_err  in  2  bid_err_t response.
- win  in  1  win flag from controller.
- balance  in  DATAWIDTH  current balance.
- bid  out  1  bid request.
- bid_amt  out  DATAWIDTH  bid amount, valid when bid=1.
- retract  out  1  retract request.
- last_bid  out  DATAWIDTH  standing accepted bid (0 = none).
- won  out  1  sticky until next round starts.
- done  out  1  one-cycle pulse when the round result is known.
- gave_up  out  1  agent stopped bidding this round.
- bids_placed  out  8  accepted bids this round; saturates at 255.

Behaviour:
- Reset (sync, high): state IDLE. All outputs 0. Config registers 0. Reset mid-round drops bid and retract in the next cycle with no retract pulse.
- States: IDLE, ARMED, EVAL, BID, HOLD, BACKOFF, GIVEUP, RESULT.
- IDLE: cfg_load → ARMED.
- ARMED: round_active=1 → EVAL. On entry: clear won, gave_up, bids_placed, last_bid.
- EVAL (1 cycle, combinational candidate):
  - cand = (max_bid==0) ? cfg_start : max_bid+cfg_step, computed in DATAWIDTH+1 bits.
  - Carry out or cand>cfg_cap → GIVEUP.
  - cand+cfg_charge > balance (DATAWIDTH+1 compare) → GIVEUP.
  - max_bid==last_bid and last_bid!=0 (already leading) → HOLD.
  - Else → BID.
- BID: bid=1 and bid_amt=cand for exactly one cycle; the response is sampled in the same cycle.
  - ack=1 → last_bid<=cand, bids_placed++, → HOLD.
  - bid_err INSUFFICIENTFUNDS or INVALIDREQUEST → GIVEUP.
  - ack=0 with NOBIDERROR → treated as INVALIDREQUEST.
- HOLD:
  - withdraw=1 → retract=1 for one cycle, last_bid<=0, → GIVEUP.
  - Else max_bid>last_bid → BACKOFF (counter loaded with BACKOFF).
  - withdraw has priority over outbid.
- BACKOFF: decrement the counter; at 0 → EVAL. BACKOFF=0 goes straight to EVAL.
- GIVEUP: gave_up=1. No bid or retract.
- round_active=0 observed in any state EVAL..GIVEUP → RESULT in the next cycle. This has priority over every other transition. bid is never asserted while round_active=0.
- RESULT:
  - On round_over: won<=win, pulse done, → ARMED (config retained).
  - round_active reasserting before round_over → ARMED, done pulses with won=0.
- cfg_load outside IDLE/ARMED is ignored.

Decomposition:
- Package bids22defs gets:
  - bid_err_t (2 bits: NOBIDERROR=0, INVALIDREQUEST=1, INSUFFICIENTFUNDS=2, reserved=3).
  - agent_state_t enum.
  - BIDS_MAXBIDS=255.
- One sub-module bid_backoff_ctr: load, decrement and zero-flag counter parameterised by BACKOFF.

Test Plan:
- Solo win: cfg start=10, cap=50, step=5, charge=1; balance=100, max_bid=0, ack same cycle → bid_amt=10, last_bid=10. Round ends with win=1 → done pulse, won=1, bids_placed=1.
- Outbid ladder: after own bid 10, max_bid→20, BACKOFF=2 → exactly 2 idle cycles, then bid_amt=25. max_bid→48 → cand 53>cap → gave_up=1, no bid.
- Funds: balance=12, charge=3, cand=10 → 13>12 → GIVEUP with bid never asserted. Also controller returns INSUFFICIENTFUNDS on a bid → GIVEUP, last_bid unchanged.
- Withdraw while outbid in the same cycle: last_bid=30, withdraw=1 and max_bid=40 together → retract for 1 cycle, last_bid=0, no further bid.
- Overflow: DATAWIDTH=8, max_bid=250, step=10 → carry detected → GIVEUP, no bid_amt=4.
- Round end and reset: round_active drops during BACKOFF → RESULT, no bid. Reset asserted mid-BID → next cycle bid=0 and all outputs 0, state IDLE.
